// File: rtl/tinyqv_time_pkg.sv
// Shared time-domain definitions for the tinyqv timer and alarm scheduler:
// command op-codes, the expiry window and the wrap-tolerant deadline test.
package tinyqv_time_pkg;

  localparam int unsigned TIME_W     = 32;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned WINDOW_MSB = 30;

  localparam logic [OP_W-1:0] OP_ARM        = 2'd0;
  localparam logic [OP_W-1:0] OP_DISARM     = 2'd1;
  localparam logic [OP_W-1:0] OP_SET_PERIOD = 2'd2;
  localparam logic [OP_W-1:0] OP_ACK        = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TIME_W-1:0] data;
  } alarm_cmd_t;

  // Deadline counts as reached while now lies in [deadline, deadline + 2^WINDOW_MSB)
  function automatic logic time_reached(input logic [TIME_W-1:0] now,
                                        input logic [TIME_W-1:0] deadline);
    logic [TIME_W-1:0] diff;
    diff = now - deadline;
    return diff[TIME_W-1:WINDOW_MSB] == '0;
  endfunction

endpackage

// File: rtl/tinyqv_alarm_slot.sv
// One alarm slot: deadline, armed/pending flags and (with ALARM_PERIODIC_EN)
// a reload period. Resolves a scan fire against a same-edge command.
module tinyqv_alarm_slot
  import tinyqv_time_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  alarm_cmd_t        cmd,
  input  logic              fire,
  output logic [TIME_W-1:0] deadline,
  output logic              armed,
  output logic              pending
);

  logic [TIME_W-1:0] deadline_d;
  logic              armed_d;
  logic              pending_d;
  logic              cmd_arm_c;
  logic              cmd_disarm_c;
  logic              cmd_ack_c;
  logic              fire_ok_c;

`ifdef ALARM_PERIODIC_EN
  logic [TIME_W-1:0] period;
  logic [TIME_W-1:0] period_d;
  logic              cmd_set_period_c;
`endif

  always_comb begin
    deadline_d   = deadline;
    armed_d      = armed;
    pending_d    = pending;
    cmd_arm_c    = cmd_valid && (cmd.op == OP_ARM);
    cmd_disarm_c = cmd_valid && (cmd.op == OP_DISARM);
    cmd_ack_c    = cmd_valid && (cmd.op == OP_ACK);
    // ARM and DISARM override a fire landing on the same edge
    fire_ok_c    = fire && !cmd_arm_c && !cmd_disarm_c;
`ifdef ALARM_PERIODIC_EN
    period_d         = period;
    cmd_set_period_c = cmd_valid && (cmd.op == OP_SET_PERIOD);
`endif

    if (fire_ok_c) begin
      pending_d = 1'b1;
`ifdef ALARM_PERIODIC_EN
      if (period != '0) begin
        deadline_d = deadline + period;
      end else begin
        armed_d = 1'b0;
      end
`else
      armed_d = 1'b0;
`endif
    end

    if (cmd_arm_c) begin
      deadline_d = cmd.data;
      armed_d    = 1'b1;
      pending_d  = 1'b0;
    end

    if (cmd_disarm_c) begin
      armed_d = 1'b0;
    end

    // A fire on the acknowledge edge keeps the new event visible
    if (cmd_ack_c && !fire_ok_c) begin
      pending_d = 1'b0;
    end

`ifdef ALARM_PERIODIC_EN
    if (cmd_set_period_c) begin
      period_d = cmd.data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deadline <= '0;
      armed    <= 1'b0;
      pending  <= 1'b0;
`ifdef ALARM_PERIODIC_EN
      period   <= '0;
`endif
    end else begin
      deadline <= deadline_d;
      armed    <= armed_d;
      pending  <= pending_d;
`ifdef ALARM_PERIODIC_EN
      period   <= period_d;
`endif
    end
  end

endmodule

// File: rtl/tinyqv_alarm_sched.sv
// Alarm scheduler: NUM_ALARMS slots share one wrap-tolerant deadline comparator
// visited round-robin against mtime. Optional feature macro: ALARM_PERIODIC_EN.
module tinyqv_alarm_sched
  import tinyqv_time_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned SLOT_W     = $clog2(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TIME_W-1:0]     mtime,
  input  logic                  cfg_valid,
  input  logic [OP_W-1:0]       cfg_op,
  input  logic [SLOT_W-1:0]     cfg_slot,
  input  logic [TIME_W-1:0]     cfg_data,
  input  logic [SLOT_W-1:0]     rd_slot,
  output logic [TIME_W-1:0]     rd_data,
  output logic [NUM_ALARMS-1:0] armed,
  output logic [NUM_ALARMS-1:0] pending,
  output logic                  irq
);

  logic [SLOT_W-1:0]     scan_idx;
  logic [TIME_W-1:0]     deadline [NUM_ALARMS];
  logic                  expired_c;
  logic [NUM_ALARMS-1:0] fire_c;
  alarm_cmd_t            cmd_c;

  assign cmd_c     = '{op: cfg_op, data: cfg_data};
  assign expired_c = time_reached(mtime, deadline[scan_idx]);
  assign rd_data   = deadline[rd_slot];

  for (genvar i = 0; i < int'(NUM_ALARMS); i++) begin : g_slot
    logic sel_c;
    assign sel_c     = cfg_valid && (cfg_slot == SLOT_W'(i));
    assign fire_c[i] = expired_c && armed[i] && (scan_idx == SLOT_W'(i));

    tinyqv_alarm_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(sel_c),
      .cmd      (cmd_c),
      .fire     (fire_c[i]),
      .deadline (deadline[i]),
      .armed    (armed[i]),
      .pending  (pending[i])
    );
  end

  // Round-robin scan pointer wraps naturally for a power-of-two slot count
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx <= '0;
      irq      <= 1'b0;
    end else begin
      scan_idx <= scan_idx + SLOT_W'(1);
      irq      <= |pending;
    end
  end

endmodule

// File: tb/tb_tinyqv_alarm_sched.sv
// Self-checking bench for tinyqv_alarm_sched: boundary table, directed
// corner sequences and random traffic against a behavioural slot model.
module tb_tinyqv_alarm_sched;
  import tinyqv_time_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;
`ifdef ALARM_PERIODIC_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [31:0]   mtime;
  logic          cfg_valid;
  logic [1:0]    cfg_op;
  logic [SW-1:0] cfg_slot;
  logic [31:0]   cfg_data;
  logic [SW-1:0] rd_slot;
  logic [31:0]   rd_data;
  logic [N-1:0]  armed;
  logic [N-1:0]  pending;
  logic          irq;

  tinyqv_alarm_sched #(.NUM_ALARMS(N), .SLOT_W(SW)) dut (
    .clk(clk), .rst(rst), .mtime(mtime), .cfg_valid(cfg_valid), .cfg_op(cfg_op),
    .cfg_slot(cfg_slot), .cfg_data(cfg_data), .rd_slot(rd_slot), .rd_data(rd_data),
    .armed(armed), .pending(pending), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: what software would believe each slot holds
  logic [31:0] m_dl  [N];
  logic [31:0] m_per [N];
  logic [N-1:0] m_arm  = '0;
  logic [N-1:0] m_pend = '0;
  logic         m_irq  = 1'b0;
  int           m_scan = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: predict from spec rules, clock the DUT, compare everything
  task automatic tick();
    logic [31:0]  n_dl  [N];
    logic [31:0]  n_per [N];
    logic [N-1:0] n_arm;
    logic [N-1:0] n_pend;
    logic         n_irq;
    logic [31:0]  age;
    bit           due, to_me, overridden;
    n_arm  = m_arm;
    n_pend = m_pend;
    n_irq  = (m_pend != '0);
    for (int i = 0; i < N; i++) begin
      n_dl[i]  = m_dl[i];
      n_per[i] = m_per[i];
      age      = mtime - m_dl[i];
      due      = (i == m_scan) && m_arm[i] && (age < 32'h4000_0000);
      to_me    = cfg_valid && (int'(cfg_slot) == i);
      overridden = to_me && (cfg_op == OP_ARM || cfg_op == OP_DISARM);
      if (due && !overridden) begin
        n_pend[i] = 1'b1;
        if (PERIODIC && m_per[i] != 0) n_dl[i] = m_dl[i] + m_per[i];
        else                           n_arm[i] = 1'b0;
      end
      if (to_me) begin
        case (cfg_op)
          OP_ARM:        begin n_dl[i] = cfg_data; n_arm[i] = 1'b1; n_pend[i] = 1'b0; end
          OP_DISARM:     n_arm[i] = 1'b0;
          OP_ACK:        if (!due) n_pend[i] = 1'b0;
          OP_SET_PERIOD: if (PERIODIC) n_per[i] = cfg_data;
          default:       ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_dl[i] = '0; m_per[i] = '0; end
      m_arm = '0; m_pend = '0; m_irq = 1'b0; m_scan = 0;
    end else begin
      for (int i = 0; i < N; i++) begin m_dl[i] = n_dl[i]; m_per[i] = n_per[i]; end
      m_arm = n_arm; m_pend = n_pend; m_irq = n_irq; m_scan = (m_scan + 1) % N;
    end
    cfg_valid = 1'b0;
    check("armed",   32'(armed),   32'(m_arm));
    check("pending", 32'(pending), 32'(m_pend));
    check("irq",     32'(irq),     32'(m_irq));
    check("rd_data", rd_data,      m_dl[rd_slot]);
  endtask

  task automatic send(input logic [1:0] op, input int slot, input logic [31:0] data);
    cfg_valid = 1'b1;
    cfg_op    = op;
    cfg_slot  = SW'(slot);
    cfg_data  = data;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Tick until the scan pointer is about to visit slot s (bounded by N)
  task automatic wait_scan(input int s);
    for (int k = 0; k < N && m_scan != s; k++) tick();
  endtask

  typedef struct {
    logic [31:0] mt;
    logic [31:0] dl;
    int          slot;
    logic        fires;
  } vec_t;

  vec_t vt [8];

  initial begin
    bit          seen;
    int          kp;
    logic [31:0] mr;
    int          off;

    for (int i = 0; i < N; i++) begin m_dl[i] = '0; m_per[i] = '0; end
    rst = 1'b1; mtime = 32'd100; cfg_valid = 1'b0; cfg_op = '0;
    cfg_slot = '0; cfg_data = '0; rd_slot = '0;

    // Reset and idle hold
    do_reset();
    mtime = 32'd100;
    repeat (16) tick();
    check("reset_armed",   32'(armed),   32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_irq",     32'(irq),     32'd0);
    for (int s = 0; s < N; s++) begin
      rd_slot = SW'(s);
      #1;
      check("reset_rd_data", rd_data, 32'd0);
    end

    // Window boundary table
    vt[0] = '{32'd1000,       32'd1000,       0, 1'b1};
    vt[1] = '{32'd1000,       32'd1001,       1, 1'b0};
    vt[2] = '{32'h4000_0005,  32'd5,          2, 1'b0};
    vt[3] = '{32'h4000_0004,  32'd5,          3, 1'b1};
    vt[4] = '{32'h8000_0000,  32'h0000_0000,  0, 1'b0};
    vt[5] = '{32'h8000_0000,  32'h7FFF_FF00,  1, 1'b1};
    vt[6] = '{32'h0000_0005,  32'hFFFF_FFFA,  2, 1'b1};
    vt[7] = '{32'hFFFF_FFF0,  32'h0000_0010,  3, 1'b0};
    for (int v = 0; v < 8; v++) begin
      do_reset();
      mtime   = vt[v].mt;
      rd_slot = SW'(vt[v].slot);
      send(OP_ARM, vt[v].slot, vt[v].dl);
      repeat (N + 1) tick();
      check("tbl_pending", 32'(pending[vt[v].slot]), 32'(vt[v].fires));
      check("tbl_armed",   32'(armed[vt[v].slot]),   32'(!vt[v].fires));
      check("tbl_irq",     32'(irq),                 32'(vt[v].fires));
      check("tbl_rd_data", rd_data,                  vt[v].dl);
    end

    // Slot 2 deadline 500 with mtime stepping up
    do_reset();
    mtime = 32'd0; rd_slot = 2'd2;
    send(OP_ARM, 2, 32'd500);
    seen = 1'b0; kp = 0;
    for (int k = 1; k <= 600; k++) begin
      mtime = 32'(k);
      tick();
      if (seen && k == kp + 1) check("slot2_irq_follows", 32'(irq), 32'd1);
      if (!seen && pending[2]) begin
        seen = 1'b1; kp = k;
        check("slot2_irq_not_yet", 32'(irq), 32'd0);
      end
    end
    check("slot2_fired", 32'(seen), 32'd1);
    check("slot2_latency_ok", 32'(kp >= 500 && kp <= 500 + N), 32'd1);
    check("slot2_one_shot", 32'(armed[2]), 32'd0);

    // Deadline just past the 32-bit wrap
    do_reset();
    mtime = 32'hFFFF_FFF0; rd_slot = 2'd1;
    send(OP_ARM, 1, 32'h0000_0010);
    seen = 1'b0; mr = '0;
    for (int k = 0; k < 48; k++) begin
      mtime = 32'hFFFF_FFF1 + 32'(k);
      tick();
      if (!seen && pending[1]) begin seen = 1'b1; mr = mtime; end
    end
    check("wrap_fired", 32'(seen), 32'd1);
    check("wrap_not_early_not_late", 32'((mr - 32'h10) <= 32'(N)), 32'd1);

    // ARM on the fire edge: command wins
    do_reset();
    mtime = 32'd2000; rd_slot = 2'd0;
    tick();
    send(OP_ARM, 0, 32'd2000);
    wait_scan(0);
    send(OP_ARM, 0, 32'd5000);
    check("col_arm_pending", 32'(pending[0]), 32'd0);
    check("col_arm_armed",   32'(armed[0]),   32'd1);
    check("col_arm_deadline", rd_data,        32'd5000);

    // ACK on the fire edge: pending survives
    if (m_scan == 0) tick();
    send(OP_ARM, 0, 32'd2000);
    wait_scan(0);
    send(OP_ACK, 0, 32'd0);
    check("col_ack_pending", 32'(pending[0]), 32'd1);
    check("col_ack_armed",   32'(armed[0]),   32'd0);

    // DISARM on the fire edge: fire discarded, pending untouched (cleared first)
    send(OP_ACK, 0, 32'd0);
    if (m_scan == 0) tick();
    send(OP_ARM, 0, 32'd2000);
    wait_scan(0);
    send(OP_DISARM, 0, 32'd0);
    check("col_disarm_pending", 32'(pending[0]), 32'd0);
    check("col_disarm_armed",   32'(armed[0]),   32'd0);

    // Fire on slot 0 while slot 1 is armed on the same edge
    if (m_scan == 0) tick();
    send(OP_ARM, 0, 32'd2000);
    wait_scan(0);
    rd_slot = 2'd1;
    send(OP_ARM, 1, 32'd9999);
    check("indep_pending0", 32'(pending[0]), 32'd1);
    check("indep_armed1",   32'(armed[1]),   32'd1);
    check("indep_rd1",      rd_data,         32'd9999);

    // Period register behaviour
    do_reset();
    mtime = 32'd990; rd_slot = 2'd3;
    send(OP_SET_PERIOD, 3, 32'd100);
    send(OP_ARM, 3, 32'd1000);
`ifdef ALARM_PERIODIC_EN
    for (int t = 991; t <= 1250; t++) begin
      mtime = 32'(t);
      tick();
      if (t == 1010) check("per_reload_1100", rd_data, 32'd1100);
      if (t == 1110) check("per_reload_1200", rd_data, 32'd1200);
      if (t == 1210) check("per_reload_1300", rd_data, 32'd1300);
    end
    check("per_still_armed", 32'(armed[3]),   32'd1);
    check("per_pending",     32'(pending[3]), 32'd1);
`else
    for (int t = 991; t <= 1010; t++) begin
      mtime = 32'(t);
      tick();
    end
    check("oneshot_disarmed", 32'(armed[3]),   32'd0);
    check("oneshot_pending",  32'(pending[3]), 32'd1);
    check("oneshot_deadline", rd_data,         32'd1000);
`endif

    // Random traffic with occasional mtime jumps and resets
    do_reset();
    mtime = $urandom;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) mtime = $urandom;
      else                            mtime = mtime + 32'($urandom_range(0, 3));
      rd_slot = SW'($urandom_range(0, N - 1));
      rst     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) < 3) begin
        cfg_valid = 1'b1;
        cfg_op    = 2'($urandom_range(0, 3));
        cfg_slot  = SW'($urandom_range(0, N - 1));
        off       = int'($urandom_range(0, 600)) - 200;
        if (cfg_op == OP_SET_PERIOD) cfg_data = 32'($urandom_range(0, 3) * 40);
        else if ($urandom_range(0, 7) == 0) cfg_data = $urandom;
        else cfg_data = mtime + 32'(off);
      end
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
